// File: rtl/gem_kchar_gen.sv
// gem_kchar_gen: BX-aligned K-character generator for the four GEM fibers (OH0: 0/1, OH1: 2/3).
// Define GEM_SKEW_INJECT_EN to compile in the per-fiber 0..3 cycle skew delay lines.
module gem_kchar_gen #(
    parameter int unsigned BX_PERIOD  = 3564,
    parameter int unsigned RESYNC_LEN = 4
) (
    input  logic        clock,
    input  logic        global_reset_n,
    input  logic        gen_en,
    input  logic        ttc_resync,
    input  logic [7:0]  gem_skew,
    output logic [7:0]  gem0_kchar,
    output logic [7:0]  gem1_kchar,
    output logic [7:0]  gem2_kchar,
    output logic [7:0]  gem3_kchar,
    output logic [11:0] bx_cnt,
    output logic        running,
    output logic [7:0]  resync_cnt
);

    localparam int unsigned KW   = 8;
    localparam int unsigned BXW  = 12;
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESYNC = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_BAD    = 2'd3;

    localparam logic [KW-1:0] K_IDLE   = 8'hBC;
    localparam logic [KW-1:0] K_RESYNC = 8'h3C;
    localparam logic [KW-1:0] K_BC0    = 8'h1C;
    localparam logic [KW-1:0] K_RUN0   = 8'hBC;
    localparam logic [KW-1:0] K_RUN1   = 8'hF7;
    localparam logic [KW-1:0] K_RUN2   = 8'hFB;
    localparam logic [KW-1:0] K_RUN3   = 8'hFD;

    localparam logic [CNTW-1:0] RCNT_LAST  = CNTW'(RESYNC_LEN - 1);
    localparam logic [BXW-1:0]  BX_LAST    = BXW'(BX_PERIOD - 1);
    localparam logic [CNTW-1:0] RSYNC_SAT  = {CNTW{1'b1}};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_restart;
    logic [CNTW-1:0] r_rcnt;
    logic [CNTW-1:0] w_rcnt_nxt;
    logic [BXW-1:0]  r_bx_cnt;
    logic [BXW-1:0]  w_bx_nxt;
    logic [KW-1:0]   r_base;
    logic [KW-1:0]   w_code;
    logic            r_running;
    logic [CNTW-1:0] r_resync_cnt;
    logic [CNTW-1:0] w_resync_cnt_nxt;

    // Next state; a cleared gen_en overrides everything, including a coincident resync.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        if (!gen_en || (r_state == ST_BAD)) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_RESYNC;
            w_restart   = 1'b1;
        end else if (ttc_resync) begin
            w_state_nxt = ST_RESYNC;
            w_restart   = 1'b1;
        end else if ((r_state == ST_RESYNC) && (r_rcnt == RCNT_LAST)) begin
            w_state_nxt = ST_RUN;
        end
    end

    // RESYNC dwell counter, BX counter and accepted-resync counter.
    always_comb begin
        w_rcnt_nxt       = r_rcnt;
        w_bx_nxt         = '0;
        w_resync_cnt_nxt = r_resync_cnt;
        if (w_restart) begin
            w_rcnt_nxt = '0;
        end else if (r_state == ST_RESYNC) begin
            w_rcnt_nxt = r_rcnt + CNTW'(1);
        end
        if (r_state == ST_RUN) begin
            w_bx_nxt = (r_bx_cnt == BX_LAST) ? '0 : r_bx_cnt + BXW'(1);
        end
        if (ttc_resync && gen_en && (r_resync_cnt != RSYNC_SAT)) begin
            w_resync_cnt_nxt = r_resync_cnt + CNTW'(1);
        end
    end

    // Base K-char for the current state and BX position.
    always_comb begin
        w_code = K_IDLE;
        unique case (r_state)
            ST_RESYNC: w_code = K_RESYNC;
            ST_RUN: begin
                if (r_bx_cnt == '0) begin
                    w_code = K_BC0;
                end else begin
                    unique case (r_bx_cnt[1:0])
                        2'd0:    w_code = K_RUN0;
                        2'd1:    w_code = K_RUN1;
                        2'd2:    w_code = K_RUN2;
                        default: w_code = K_RUN3;
                    endcase
                end
            end
            default: w_code = K_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state      <= ST_IDLE;
            r_rcnt       <= '0;
            r_bx_cnt     <= '0;
            r_base       <= K_IDLE;
            r_running    <= 1'b0;
            r_resync_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_bx_cnt     <= w_bx_nxt;
            r_base       <= w_code;
            r_running    <= (r_state == ST_RUN);
            r_resync_cnt <= w_resync_cnt_nxt;
        end
    end

    assign bx_cnt     = r_bx_cnt;
    assign running    = r_running;
    assign resync_cnt = r_resync_cnt;

`ifdef GEM_SKEW_INJECT_EN
    logic [KW-1:0] r_tap [1:3];
    logic [KW-1:0] w_taps [4];

    // Shared delay line; each fiber picks its tap combinationally so skew changes act at once.
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int k = 1; k < 4; k++) begin
                r_tap[k] <= K_IDLE;
            end
        end else begin
            r_tap[1] <= r_base;
            r_tap[2] <= r_tap[1];
            r_tap[3] <= r_tap[2];
        end
    end

    assign w_taps[0] = r_base;
    assign w_taps[1] = r_tap[1];
    assign w_taps[2] = r_tap[2];
    assign w_taps[3] = r_tap[3];

    assign gem0_kchar = w_taps[gem_skew[1:0]];
    assign gem1_kchar = w_taps[gem_skew[3:2]];
    assign gem2_kchar = w_taps[gem_skew[5:4]];
    assign gem3_kchar = w_taps[gem_skew[7:6]];
`else
    logic w_unused_skew;

    assign w_unused_skew = ^gem_skew;
    assign gem0_kchar    = r_base;
    assign gem1_kchar    = r_base;
    assign gem2_kchar    = r_base;
    assign gem3_kchar    = r_base;
`endif

endmodule

// File: tb/tb_gem_kchar_gen.sv
// Self-checking bench for gem_kchar_gen: constant vector table, directed corner sequences,
// and randomized traffic against a history-based reference model (honours GEM_SKEW_INJECT_EN).
module tb_gem_kchar_gen;

    localparam int BXP = 8;
    localparam int RL  = 4;

    logic        clock          = 1'b0;
    logic        global_reset_n = 1'b1;
    logic        gen_en         = 1'b0;
    logic        ttc_resync     = 1'b0;
    logic [7:0]  gem_skew       = 8'h00;
    logic [7:0]  gem0_kchar;
    logic [7:0]  gem1_kchar;
    logic [7:0]  gem2_kchar;
    logic [7:0]  gem3_kchar;
    logic [11:0] bx_cnt;
    logic        running;
    logic [7:0]  resync_cnt;

    gem_kchar_gen #(
        .BX_PERIOD  (BXP),
        .RESYNC_LEN (RL)
    ) u_dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .gen_en         (gen_en),
        .ttc_resync     (ttc_resync),
        .gem_skew       (gem_skew),
        .gem0_kchar     (gem0_kchar),
        .gem1_kchar     (gem1_kchar),
        .gem2_kchar     (gem2_kchar),
        .gem3_kchar     (gem3_kchar),
        .bx_cnt         (bx_cnt),
        .running        (running),
        .resync_cnt     (resync_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: mode (0 idle, 1 resync, 2 run), cycles spent in resync, BX position,
    // and a history of generated words where m_hist[k] is the word generated k cycles ago.
    int         m_mode;
    int         m_dwell;
    int         m_bx;
    int         m_rs;
    logic       m_run;
    logic [7:0] m_hist [4];

    function automatic logic [7:0] code_of(input int mode, input int bx);
        logic [7:0] run_codes [4];
        run_codes = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
        if (mode == 0) return 8'hBC;
        if (mode == 1) return 8'h3C;
        if (bx == 0)   return 8'h1C;
        return run_codes[bx % 4];
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_dwell = 0;
        m_bx    = 0;
        m_rs    = 0;
        m_run   = 1'b0;
        for (int k = 0; k < 4; k++) m_hist[k] = 8'hBC;
    endtask

    task automatic model_edge(input logic ge, input logic rs);
        int nmode;
        int nbx;
        int ndwell;
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = code_of(m_mode, m_bx);
        m_run     = (m_mode == 2);
        if (ge && rs && m_rs < 255) m_rs = m_rs + 1;
        nbx    = (m_mode == 2) ? (m_bx + 1) % BXP : 0;
        ndwell = (m_mode == 1) ? m_dwell + 1 : m_dwell;
        nmode  = m_mode;
        if (!ge) begin
            nmode = 0;
        end else if (m_mode == 0 || rs) begin
            nmode  = 1;
            ndwell = 0;
        end else if (m_mode == 1 && m_dwell == RL - 1) begin
            nmode = 2;
        end
        m_mode  = nmode;
        m_bx    = nbx;
        m_dwell = ndwell;
    endtask

    task automatic compare_model(input string tag);
        logic [7:0] fib [4];
        int sel;
        fib[0] = gem0_kchar;
        fib[1] = gem1_kchar;
        fib[2] = gem2_kchar;
        fib[3] = gem3_kchar;
        for (int i = 0; i < 4; i++) begin
`ifdef GEM_SKEW_INJECT_EN
            sel = int'(gem_skew[2*i +: 2]);
`else
            sel = 0;
`endif
            check($sformatf("%s fiber%0d", tag, i), 32'(fib[i]), 32'(m_hist[sel]));
        end
        check({tag, " bx_cnt"}, 32'(bx_cnt), 32'(m_bx));
        check({tag, " running"}, 32'(running), 32'(m_run));
        check({tag, " resync_cnt"}, 32'(resync_cnt), 32'(m_rs));
    endtask

    task automatic step(input logic ge, input logic rs, input string tag);
        gen_en     = ge;
        ttc_resync = rs;
        @(posedge clock);
        model_edge(ge, rs);
        #1;
        compare_model(tag);
    endtask

    // Asynchronous reset: outputs must return to reset values without waiting for a clock edge.
    task automatic apply_reset(input string tag);
        gen_en         = 1'b0;
        ttc_resync     = 1'b0;
        global_reset_n = 1'b0;
        #1;
        model_reset();
        compare_model(tag);
        check({tag, " k0 const"}, 32'(gem0_kchar), 32'h0BC);
        check({tag, " k3 const"}, 32'(gem3_kchar), 32'h0BC);
        check({tag, " running const"}, 32'(running), 32'h0);
        check({tag, " resync const"}, 32'(resync_cnt), 32'h0);
        @(posedge clock);
        #1;
        global_reset_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] k;
        logic       run;
        int         bx;
    } vec_t;

    vec_t tbl [14];
    int   n_diff;
    int   exp_diff;

    initial begin
        // Expected outputs after each edge following gen_en rising at edge M (BX_PERIOD 8, RESYNC_LEN 4).
        tbl[0]  = '{8'hBC, 1'b0, 0};
        tbl[1]  = '{8'h3C, 1'b0, 0};
        tbl[2]  = '{8'h3C, 1'b0, 0};
        tbl[3]  = '{8'h3C, 1'b0, 0};
        tbl[4]  = '{8'h3C, 1'b0, 0};
        tbl[5]  = '{8'h1C, 1'b1, 1};
        tbl[6]  = '{8'hF7, 1'b1, 2};
        tbl[7]  = '{8'hFB, 1'b1, 3};
        tbl[8]  = '{8'hFD, 1'b1, 4};
        tbl[9]  = '{8'hBC, 1'b1, 5};
        tbl[10] = '{8'hF7, 1'b1, 6};
        tbl[11] = '{8'hFB, 1'b1, 7};
        tbl[12] = '{8'hFD, 1'b1, 0};
        tbl[13] = '{8'h1C, 1'b1, 1};

        #2;
        apply_reset("reset");

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, "idle");
            check("idle k0", 32'(gem0_kchar), 32'h0BC);
            check("idle running", 32'(running), 32'h0);
            check("idle bx", 32'(bx_cnt), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, "table");
            check($sformatf("table[%0d] k0", i), 32'(gem0_kchar), 32'(tbl[i].k));
            check($sformatf("table[%0d] k2", i), 32'(gem2_kchar), 32'(tbl[i].k));
            check($sformatf("table[%0d] running", i), 32'(running), 32'(tbl[i].run));
            check($sformatf("table[%0d] bx", i), 32'(bx_cnt), 32'(tbl[i].bx));
        end

        // Resync pulse in RUN: four RESYNC words, then BC0.
        step(1'b1, 1'b1, "resync_pulse");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, "resync_dwell");
            check($sformatf("resync dwell %0d k1", i), 32'(gem1_kchar), 32'h03C);
            check($sformatf("resync dwell %0d running", i), 32'(running), 32'h0);
        end
        step(1'b1, 1'b0, "resync_exit");
        check("resync exit k0", 32'(gem0_kchar), 32'h01C);
        check("resync exit running", 32'(running), 32'h1);
        check("resync count one", 32'(resync_cnt), 32'h1);

        // Resync coincident with gen_en falling: IDLE wins, count unchanged.
        step(1'b0, 1'b1, "resync_and_disable");
        check("disable resync_cnt", 32'(resync_cnt), 32'h1);
        step(1'b0, 1'b0, "disabled");
        check("disabled k0", 32'(gem0_kchar), 32'h0BC);
        check("disabled running", 32'(running), 32'h0);

        // Reset mid-run, then wait in IDLE.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "rerun");
        check("rerun running", 32'(running), 32'h1);
        apply_reset("midrun_reset");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, "post_reset_idle");
            check("post reset k0", 32'(gem0_kchar), 32'h0BC);
            check("post reset running", 32'(running), 32'h0);
        end

        // Saturation of the accepted-resync counter.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, "saturate");
        check("resync_cnt saturated", 32'(resync_cnt), 32'h0FF);

        // Skew on fiber0 only: two-cycle lag shows as differing words every RUN cycle.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "skew_prep");
        gem_skew = 8'b00_00_00_10;
        n_diff   = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, "skew");
            if (gem0_kchar !== gem1_kchar) n_diff++;
        end
`ifdef GEM_SKEW_INJECT_EN
        exp_diff = 16;
`else
        exp_diff = 0;
`endif
        check("skew fiber0 vs fiber1 diff count", 32'(n_diff), 32'(exp_diff));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) gem_skew = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                apply_reset("rand_reset");
            end else begin
                step(logic'($urandom_range(0, 31) != 0), logic'($urandom_range(0, 15) == 0), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
